// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS control FSM with retire counter (optional JAL_SUPPORT_EN)
module multicycle_controller #(
    parameter int CNT_W           = 32,
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic [1:0]       npc_sel,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       reg_src,
    output logic             alu_src,
    output logic [1:0]       alu_ctl,
    output logic [1:0]       ext_op,
    output logic             illegal,
    output logic             instr_retired,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef JAL_SUPPORT_EN
    localparam logic [5:0] OP_JAL   = 6'b000011;
`endif
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXE,
        S_MEM,
        S_WB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    state_t state, state_nxt;

    logic is_rtype, is_addu, is_subu, is_ori, is_lw, is_sw;
    logic is_beq, is_lui, is_j, is_jal, is_imm, is_legal;
    logic mem_ok;

    always_comb begin
        is_rtype = (opcode == OP_RTYPE);
        is_addu  = is_rtype && (funct == FN_ADDU);
        is_subu  = is_rtype && (funct == FN_SUBU);
        is_ori   = (opcode == OP_ORI);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_beq   = (opcode == OP_BEQ);
        is_lui   = (opcode == OP_LUI);
        is_j     = (opcode == OP_J);
`ifdef JAL_SUPPORT_EN
        is_jal   = (opcode == OP_JAL);
`else
        is_jal   = 1'b0;
`endif
        is_imm   = is_ori || is_lui || is_lw || is_sw;
        is_legal = is_addu || is_subu || is_imm || is_beq || is_j || is_jal;
    end

    // Without the handshake every memory access completes in its first cycle.
    assign mem_ok = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (instr_retired) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        npc_sel       = 2'b00;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        reg_src       = 2'b00;
        alu_src       = 1'b0;
        alu_ctl       = 2'b00;
        ext_op        = 2'b00;
        illegal       = 1'b0;
        instr_retired = 1'b0;

        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ok) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    npc_sel   = 2'b00;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_beq) begin
                    state_nxt = S_BRANCH;
                end else if (is_j || is_jal) begin
                    state_nxt = S_JUMP;
                end else if (is_legal) begin
                    state_nxt = S_EXE;
                end else begin
                    // Illegal encodings either park or are silently dropped without retiring.
                    state_nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                end
            end
            S_EXE: begin
                alu_src = is_imm;
                if (is_subu) begin
                    alu_ctl = 2'b01;
                end else if (is_ori) begin
                    alu_ctl = 2'b10;
                end else if (is_lui) begin
                    alu_ctl = 2'b11;
                end
                if (is_lw || is_sw) begin
                    ext_op = 2'b01;
                end else if (is_lui) begin
                    ext_op = 2'b10;
                end
                state_nxt = (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (is_sw) begin
                    mem_write = 1'b1;
                end else begin
                    mem_read = 1'b1;
                end
                if (mem_ok) begin
                    if (is_sw) begin
                        instr_retired = 1'b1;
                        state_nxt     = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write     = 1'b1;
                reg_dst       = is_rtype ? 2'b01 : 2'b00;
                reg_src       = is_lw ? 2'b01 : 2'b00;
                instr_retired = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_BRANCH: begin
                alu_ctl       = 2'b01;
                npc_sel       = 2'b01;
                pc_write      = zero;
                instr_retired = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_JUMP: begin
                npc_sel       = 2'b10;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
`ifdef JAL_SUPPORT_EN
                // jal links PC+4 into $31 in the same cycle as the jump.
                if (is_jal) begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b10;
                    reg_src   = 2'b10;
                end
`endif
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - bench for multicycle_controller (trap and no-trap instances)
module tb_multicycle_controller;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic [1:0] npc_sel;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] reg_src;
        logic       alu_src;
        logic [1:0] alu_ctl;
        logic [1:0] ext_op;
        logic       illegal;
        logic       retired;
    } exp_t;

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4;
    localparam int K_SW = 5, K_BEQ = 6, K_J = 7, K_JAL = 8, K_ILL = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic m_pc_write, m_ir_write, m_mem_read, m_mem_write, m_reg_write, m_alu_src, m_illegal, m_retired;
    logic [1:0] m_npc_sel, m_reg_dst, m_reg_src, m_alu_ctl, m_ext_op;
    logic [31:0] m_count;
    logic a_pc_write, a_ir_write, a_mem_read, a_mem_write, a_reg_write, a_alu_src, a_illegal, a_retired;
    logic [1:0] a_npc_sel, a_reg_dst, a_reg_src, a_alu_ctl, a_ext_op;
    logic [2:0] a_count;

    exp_t act_main, act_alt, exp_main, exp_alt;
    logic chk_en = 1'b0;
    logic trapped = 1'b0;
    logic [31:0] cnt_main = 32'd0;
    logic [2:0]  cnt_alt = 3'd0;
    int n_err = 0;
    int n_chk = 0;

    multicycle_controller u_main (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(m_pc_write), .ir_write(m_ir_write), .npc_sel(m_npc_sel), .mem_read(m_mem_read),
        .mem_write(m_mem_write), .reg_write(m_reg_write), .reg_dst(m_reg_dst), .reg_src(m_reg_src),
        .alu_src(m_alu_src), .alu_ctl(m_alu_ctl), .ext_op(m_ext_op), .illegal(m_illegal),
        .instr_retired(m_retired), .instr_count(m_count)
    );

    multicycle_controller #(.CNT_W(3), .MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b0)) u_alt (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(a_pc_write), .ir_write(a_ir_write), .npc_sel(a_npc_sel), .mem_read(a_mem_read),
        .mem_write(a_mem_write), .reg_write(a_reg_write), .reg_dst(a_reg_dst), .reg_src(a_reg_src),
        .alu_src(a_alu_src), .alu_ctl(a_alu_ctl), .ext_op(a_ext_op), .illegal(a_illegal),
        .instr_retired(a_retired), .instr_count(a_count)
    );

    assign act_main = {m_pc_write, m_ir_write, m_npc_sel, m_mem_read, m_mem_write, m_reg_write,
                       m_reg_dst, m_reg_src, m_alu_src, m_alu_ctl, m_ext_op, m_illegal, m_retired};
    assign act_alt  = {a_pc_write, a_ir_write, a_npc_sel, a_mem_read, a_mem_write, a_reg_write,
                       a_reg_dst, a_reg_src, a_alu_src, a_alu_ctl, a_ext_op, a_illegal, a_retired};

    always #5 clk = ~clk;

    // Per-cycle comparison of both instances against the expected vectors and retire counts.
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_main = 32'd0;
            cnt_alt  = 3'd0;
        end else if (chk_en) begin
            n_chk++;
            if (act_main !== exp_main) begin
                n_err++;
                $display("FAIL outputs_main t=%0t actual=%h required=%h", $time, act_main, exp_main);
            end
            n_chk++;
            if (m_count !== cnt_main) begin
                n_err++;
                $display("FAIL count_main t=%0t actual=%0d required=%0d", $time, m_count, cnt_main);
            end
            n_chk++;
            if (act_alt !== exp_alt) begin
                n_err++;
                $display("FAIL outputs_alt t=%0t actual=%h required=%h", $time, act_alt, exp_alt);
            end
            n_chk++;
            if (a_count !== cnt_alt) begin
                n_err++;
                $display("FAIL count_alt t=%0t actual=%0d required=%0d", $time, a_count, cnt_alt);
            end
            if (exp_main.retired) cnt_main = cnt_main + 32'd1;
            if (exp_alt.retired)  cnt_alt  = cnt_alt + 3'd1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: return (fn == 6'b100001) ? K_ADDU : (fn == 6'b100011) ? K_SUBU : K_ILL;
            6'b001101: return K_ORI;
            6'b001111: return K_LUI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
`ifdef JAL_SUPPORT_EN
            6'b000011: return K_JAL;
`endif
            default:   return K_ILL;
        endcase
    endfunction

    function automatic exp_t trap_vec();
        exp_t t;
        t = '0;
        t.illegal = 1'b1;
        return t;
    endfunction

    task automatic step(input exp_t e, input logic rdy);
        mem_ready = rdy;
        exp_alt   = e;
        exp_main  = trapped ? trap_vec() : e;
        chk_en    = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Walks one instruction through its spec-defined cycle sequence, returning its cycle count.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, input logic stop_in_mem, output int cycles);
        exp_t e;
        int k;
        k = kind(op, fn);
        opcode = op;
        funct  = fn;
        zero   = z;
        cycles = 0;
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mem_read = 1'b1;
            step(e, 1'b0); cycles++;
        end
        e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(e, 1'b1); cycles++;
        e = '0;
        step(e, 1'b0); cycles++;
        if (k == K_ILL) begin
            trapped = 1'b1;
            return;
        end
        e = '0;
        if (k == K_BEQ) begin
            e.alu_ctl = 2'b01; e.npc_sel = 2'b01; e.pc_write = z; e.retired = 1'b1;
            step(e, 1'b0); cycles++;
        end else if (k == K_J || k == K_JAL) begin
            e.npc_sel = 2'b10; e.pc_write = 1'b1; e.retired = 1'b1;
            if (k == K_JAL) begin
                e.reg_write = 1'b1; e.reg_dst = 2'b10; e.reg_src = 2'b10;
            end
            step(e, 1'b0); cycles++;
        end else begin
            e.alu_ctl = (k == K_SUBU) ? 2'b01 : (k == K_ORI) ? 2'b10 : (k == K_LUI) ? 2'b11 : 2'b00;
            e.alu_src = (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW);
            e.ext_op  = (k == K_LW || k == K_SW) ? 2'b01 : (k == K_LUI) ? 2'b10 : 2'b00;
            step(e, 1'b0); cycles++;
            if (k == K_LW || k == K_SW) begin
                e = '0;
                e.mem_read  = (k == K_LW);
                e.mem_write = (k == K_SW);
                for (int i = 0; i < mw; i++) begin
                    step(e, 1'b0); cycles++;
                end
                if (stop_in_mem) return;
                e.retired = (k == K_SW);
                step(e, 1'b1); cycles++;
            end
            if (k != K_SW) begin
                e = '0;
                e.reg_write = 1'b1;
                e.reg_dst   = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
                e.reg_src   = (k == K_LW) ? 2'b01 : 2'b00;
                e.retired   = 1'b1;
                step(e, 1'b0); cycles++;
            end
        end
    endtask

    task automatic run_lat(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw, input int lat_req);
        int lat;
        run_instr(op, fn, z, fw, mw, 1'b0, lat);
        check(name, lat, lat_req);
    endtask

    task automatic do_reset();
        exp_t e;
        chk_en    = 1'b0;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'd0;
        funct     = 6'd0;
        zero      = 1'b0;
        trapped   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs_main", act_main, 0);
            check("reset_outputs_alt", act_alt, 0);
            check("reset_count_main", m_count, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        e = '0;
        step(e, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        #2;
        do_reset();

        run_lat("lat_addu", 6'b000000, 6'b100001, 1'b0, 0, 0, 4);
        check("count_after_addu", m_count, 1);
        run_lat("lat_subu", 6'b000000, 6'b100011, 1'b0, 0, 0, 4);
        run_lat("lat_ori",  6'b001101, 6'b000000, 1'b0, 0, 0, 4);
        run_lat("lat_lui",  6'b001111, 6'b111111, 1'b0, 0, 0, 4);
        run_lat("lat_sw",   6'b101011, 6'b000000, 1'b0, 0, 0, 4);
        run_lat("lat_lw_memwait2",   6'b100011, 6'b000000, 1'b0, 0, 2, 7);
        run_lat("lat_lw_fetchwait1", 6'b100011, 6'b000000, 1'b0, 1, 0, 6);
        run_lat("lat_beq_taken",     6'b000100, 6'b000000, 1'b1, 0, 0, 3);
        run_lat("lat_beq_not_taken", 6'b000100, 6'b000000, 1'b0, 0, 0, 3);
        run_lat("lat_j",             6'b000010, 6'b000000, 1'b0, 0, 0, 3);
        run_lat("lat_sw_memwait1",   6'b101011, 6'b000000, 1'b0, 0, 1, 5);
        check("count_main_11", m_count, 11);
        check("count_alt_wrapped", a_count, 3);

        run_lat("lat_illegal_nop", 6'b111111, 6'b000000, 1'b0, 0, 0, 2);
        run_lat("lat_addu_after_trap", 6'b000000, 6'b100001, 1'b0, 0, 0, 4);
`ifdef JAL_SUPPORT_EN
        run_lat("lat_jal", 6'b000011, 6'b000000, 1'b0, 0, 0, 3);
`else
        run_lat("lat_jal_illegal", 6'b000011, 6'b000000, 1'b0, 0, 0, 2);
`endif
        run_lat("lat_bad_funct", 6'b000000, 6'b000000, 1'b0, 0, 0, 2);
        run_lat("lat_j_after_trap", 6'b000010, 6'b000000, 1'b0, 0, 0, 3);
        check("trap_illegal_held", m_illegal, 1);
        check("trap_count_frozen", m_count, 11);
`ifdef JAL_SUPPORT_EN
        check("count_alt_after_nops", a_count, 6);
`else
        check("count_alt_after_nops", a_count, 5);
`endif

        do_reset();
        run_lat("lat_addu_post_reset", 6'b000000, 6'b100001, 1'b0, 0, 0, 4);
        check("count_before_abort", m_count, 1);
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 2, 1'b1, lat);
        check("mem_write_in_stall", m_mem_write, 1);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_write_main", m_mem_write, 0);
        check("abort_mem_write_alt", a_mem_write, 0);
        check("abort_outputs_main", act_main, 0);
        check("abort_count_main", m_count, 0);
        check("abort_count_alt", a_count, 0);
        do_reset();
        run_lat("lat_addu_after_abort", 6'b000000, 6'b100001, 1'b0, 0, 0, 4);
        check("count_after_abort_addu", m_count, 1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
